// File: rtl/mem_stage.sv
// MEM stage of a 5-stage RV32I pipeline: word-wide dmem access over req/ack,
// branch/jump redirect, mem-stage forwarding value and the MEM/WB register.
module mem_stage #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        regwrite,
   input  logic        loadF,
   input  logic        storeF,
   input  logic        jalF,
   input  logic        jalrF,
   input  logic [31:0] target,
   input  logic [31:0] result,
   input  logic [31:0] store_data,
   input  logic        branch_cond,
   input  logic [4:0]  regDF,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        branch_flush,
   output logic        jal_flush,
   output logic [31:0] redirect_pc,
   output logic [4:0]  regD_mem,
   output logic [31:0] regD_val_mem,
   output logic        regwrite_mem,
   output logic [4:0]  regD_wb,
   output logic [31:0] regD_val_wb,
   output logic        regwrite_wb,
   output logic        bus_err
);

   localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic [31:0]   load_data;
   logic          mem_op;
   logic          expire;

   assign mem_op = loadF | storeF;
   // TIMEOUT=0 disables abandonment entirely; the counter then just free-runs.
   assign expire = (TIMEOUT != 0) && (wait_cnt == LAST);

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         load_data <= '0;
         bus_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (mem_op) state <= WAIT;
            end
            WAIT: begin
               // An ack on the expiry edge still completes the access normally.
               if (dmem_ack) begin
                  load_data <= dmem_rdata;
                  state     <= DONE;
               end else if (expire) begin
                  load_data <= '0;
                  bus_err   <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      dmem_addr    = '0;
      dmem_wdata   = '0;
      stall        = 1'b0;
      branch_flush = 1'b0;
      jal_flush    = 1'b0;
      redirect_pc  = '0;
      regD_mem     = '0;
      regD_val_mem = '0;
      regwrite_mem = 1'b0;
      if (rst) begin
         dmem_req     = (state == WAIT) || ((state == IDLE) && mem_op);
         dmem_we      = dmem_req && storeF;
         dmem_addr    = {result[31:2], 2'b00};
         dmem_wdata   = store_data;
         stall        = dmem_req;
         branch_flush = (state == IDLE) && branch_cond;
         jal_flush    = (state == IDLE) && (jalF || jalrF);
         redirect_pc  = (branch_flush || jal_flush) ? target : '0;
         regD_mem     = regDF;
         regD_val_mem = ((state == DONE) && loadF) ? load_data : result;
         regwrite_mem = regwrite && (regDF != 5'd0) && (!loadF || (state == DONE));
      end
   end

   // A stalled cycle inserts a bubble into WB but keeps the last rd/value visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regwrite_wb <= 1'b0;
         regD_wb     <= '0;
         regD_val_wb <= '0;
      end else if (stall) begin
         regwrite_wb <= 1'b0;
      end else begin
         regwrite_wb <= regwrite_mem;
         regD_wb     <= regDF;
         regD_val_wb <= regD_val_mem;
      end
   end

endmodule
